// File: rtl/instr_decode_buffer.sv
// instr_decode_buffer: IF/ID FIFO of {pc, instr} with head field decode; optional ILLEGAL_OPCODE_CHECK_EN flag
module instr_decode_buffer #(
  parameter int          PC_W      = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [PC_W-1:0] pc_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      func3_out,
  output logic [6:0]      func7_out,
  output logic [4:0]      rs1_addr_out,
  output logic [4:0]      rs2_addr_out,
  output logic [4:0]      rd_addr_out,
  output logic [24:0]     instr_31_7_out,
  output logic            illegal_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            push, pop;
  logic [31:0]     temp;
  assign ready_out = !flush_in && (count < CW'(DEPTH));
  assign valid_out = (count != '0) && !flush_in;
  assign push = valid_in && ready_out;
  assign pop = valid_out && ready_in && !flush_in;
  assign temp = valid_out ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc_out = valid_out ? pc_mem[rd_ptr] : '0;
  assign opcode_out = temp[6:0];
  assign rd_addr_out = temp[11:7];
  assign func3_out = temp[14:12];
  assign rs1_addr_out = temp[19:15];
  assign rs2_addr_out = temp[24:20];
  assign func7_out = temp[31:25];
  assign instr_31_7_out = temp[31:7];
`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic [DEPTH-1:0] ill_mem;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  endfunction
  assign illegal_out = valid_out && ill_mem[rd_ptr];
`else
  assign illegal_out = 1'b0;
`endif
  // occupancy and pointers; flush restarts both pointers at slot 0
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_in) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // entry storage is left uncleared by reset; count alone decides validity
  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[wr_ptr] <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
`ifdef ILLEGAL_OPCODE_CHECK_EN
      ill_mem[wr_ptr] <= !is_legal(instr_in[6:0]);
`endif
    end
  end
endmodule

// File: tb/tb_instr_decode_buffer.sv
// tb_instr_decode_buffer: directed self-checking bench for instr_decode_buffer (DEPTH=2)
module tb_instr_decode_buffer;
  logic        clk_in = 1'b0;
  logic        rst_n_in, flush_in, valid_in, ready_in;
  logic [31:0] pc_in, instr_in;
  logic        ready_out, valid_out, illegal_out;
  logic [31:0] pc_out;
  logic [6:0]  opcode_out, func7_out;
  logic [2:0]  func3_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic [24:0] instr_31_7_out;
  int checks = 0;
  int errors = 0;
`ifdef ILLEGAL_OPCODE_CHECK_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif
  instr_decode_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready_out), .pc_in(pc_in), .instr_in(instr_in), .valid_out(valid_out),
    .ready_in(ready_in), .pc_out(pc_out), .opcode_out(opcode_out), .func3_out(func3_out),
    .func7_out(func7_out), .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
    .rd_addr_out(rd_addr_out), .instr_31_7_out(instr_31_7_out), .illegal_out(illegal_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask
  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    valid_in = v;
    pc_in = pc;
    instr_in = ins;
  endtask
  initial begin
    logic [31:0] q_pc[$];
    logic [31:0] q_rd[$];
    int idx;
    logic do_pop, do_acc;
    rst_n_in = 1'b0; flush_in = 1'b0; ready_in = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #2;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_opcode", opcode_out, 7'h13);
    chk("rst_rd", rd_addr_out, 5'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_illegal", illegal_out, 1'b0);
    cyc();
    rst_n_in = 1'b1;
    // streaming, back-to-back pushes with ready_in high
    cyc();
    ready_in = 1'b1;
    offer(1'b1, 32'h100, 32'h00500093);
    #1;
    chk("s2_ready0", ready_out, 1'b1);
    chk("s2_valid0", valid_out, 1'b0);
    cyc();
    offer(1'b1, 32'h104, 32'h00208133);
    #1;
    chk("s2_valid1", valid_out, 1'b1);
    chk("s2_pc1", pc_out, 32'h100);
    chk("s2_rd1", rd_addr_out, 5'd1);
    chk("s2_rs1_1", rs1_addr_out, 5'd0);
    chk("s2_imm1", instr_31_7_out, 25'h00A001);
    chk("s2_ready1", ready_out, 1'b1);
    cyc();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s2_pc2", pc_out, 32'h104);
    chk("s2_op2", opcode_out, 7'h33);
    chk("s2_rd2", rd_addr_out, 5'd2);
    chk("s2_rs1_2", rs1_addr_out, 5'd1);
    chk("s2_rs2_2", rs2_addr_out, 5'd2);
    chk("s2_f7_2", func7_out, 7'd0);
    cyc();
    chk("s2_empty", valid_out, 1'b0);
    chk("s2_empty_op", opcode_out, 7'h13);
    // stall until full, then drain in order
    ready_in = 1'b0;
    offer(1'b1, 32'h100, 32'h00500093);
    #1;
    chk("s3_ready0", ready_out, 1'b1);
    cyc();
    offer(1'b1, 32'h104, 32'h00208133);
    #1;
    chk("s3_ready1", ready_out, 1'b1);
    chk("s3_head1", pc_out, 32'h100);
    cyc();
    offer(1'b1, 32'h108, 32'h00310193);
    #1;
    chk("s3_full", ready_out, 1'b0);
    chk("s3_head2", pc_out, 32'h100);
    cyc();
    chk("s3_full2", ready_out, 1'b0);
    chk("s3_head3", pc_out, 32'h100);
    chk("s3_rd3", rd_addr_out, 5'd1);
    ready_in = 1'b1;
    #1;
    chk("s3_nopass", ready_out, 1'b0);
    cyc();
    chk("s3_drain1", pc_out, 32'h104);
    chk("s3_ready_d", ready_out, 1'b1);
    cyc();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s3_drain2", pc_out, 32'h108);
    chk("s3_rd_c", rd_addr_out, 5'd3);
    cyc();
    chk("s3_empty", valid_out, 1'b0);
    // flush with a full buffer and an offered instruction
    ready_in = 1'b0;
    offer(1'b1, 32'h200, 32'h00500093);
    cyc();
    offer(1'b1, 32'h204, 32'h00208133);
    cyc();
    offer(1'b1, 32'h208, 32'h00310193);
    flush_in = 1'b1;
    #1;
    chk("s4_op", opcode_out, 7'h13);
    chk("s4_valid", valid_out, 1'b0);
    chk("s4_ready", ready_out, 1'b0);
    chk("s4_pc", pc_out, 32'h0);
    cyc();
    flush_in = 1'b0;
    ready_in = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s4_after", valid_out, 1'b0);
    chk("s4_after_rdy", ready_out, 1'b1);
    cyc();
    chk("s4_nounder", valid_out, 1'b0);
    offer(1'b1, 32'h20C, 32'h00208133);
    cyc();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s4_refill", pc_out, 32'h20C);
    chk("s4_refill_v", valid_out, 1'b1);
    cyc();
    // asynchronous reset with two entries held
    ready_in = 1'b0;
    offer(1'b1, 32'h500, 32'h00500093);
    cyc();
    offer(1'b1, 32'h504, 32'h00208133);
    cyc();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s1_pre_full", ready_out, 1'b0);
    rst_n_in = 1'b0;
    #1;
    chk("s1_valid", valid_out, 1'b0);
    chk("s1_opcode", opcode_out, 7'h13);
    chk("s1_pc", pc_out, 32'h0);
    chk("s1_ready", ready_out, 1'b1);
    cyc();
    rst_n_in = 1'b1;
    // illegal opcode flag
    offer(1'b1, 32'h400, 32'h0000007F);
    cyc();
    ready_in = 1'b1;
    offer(1'b1, 32'h404, 32'h00000013);
    #1;
    chk("s6_valid", valid_out, 1'b1);
    chk("s6_ill", illegal_out, EXP_ILL);
    cyc();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    chk("s6_pc2", pc_out, 32'h404);
    chk("s6_legal", illegal_out, 1'b0);
    cyc();
    // ten instructions with alternating ready_in across pointer wrap
    idx = 0;
    for (int c = 0; c < 60 && (idx < 10 || q_pc.size() > 0); c++) begin
      cyc();
      ready_in = c[0];
      offer(idx < 10, 32'h300 + 32'(4 * idx), 32'h33 | 32'(idx << 7));
      #1;
      chk("s5_ready", ready_out, 32'(q_pc.size() < 2));
      chk("s5_valid", valid_out, 32'(q_pc.size() > 0));
      if (q_pc.size() > 0) begin
        chk("s5_pc", pc_out, q_pc[0]);
        chk("s5_rd", rd_addr_out, q_rd[0]);
      end
      do_pop = q_pc.size() > 0 && ready_in;
      do_acc = valid_in && q_pc.size() < 2;
      if (do_pop) begin
        void'(q_pc.pop_front());
        void'(q_rd.pop_front());
      end
      if (do_acc) begin
        q_pc.push_back(pc_in);
        q_rd.push_back(32'(idx));
        idx++;
      end
    end
    chk("s5_done", 32'(idx == 10 && q_pc.size() == 0), 32'd1);
    offer(1'b0, 32'h0, 32'h0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
